// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings, FSM states
// and status flag bit positions.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MUL     = 3'd1,
        S_DIV     = 3'd2,
        S_DIV_FIX = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_div_core.sv
// Non-restoring divider on operand magnitudes, one quotient bit per step;
// quot/rem present the restored, sign-corrected result of the current state.
module alu_div_core #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);

    // Two guard bits: the shifted partial remainder spans (-2|d|, 2|d|) and |d| can reach 2^(W-1).
    localparam int RW = W + 2;

    logic [RW-1:0] part;
    logic [RW-1:0] part_next;
    logic [RW-1:0] shifted;
    logic [RW-1:0] d_ext;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  d_mag;
    logic [W-1:0]  rem_mag;
    logic          neg_q;
    logic          neg_r;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? -v : v;
    endfunction

    always_comb begin
        shifted   = {part[RW-2:0], q_reg[W-1]};
        d_ext     = {2'b00, d_mag};
        part_next = part[RW-1] ? shifted + d_ext : shifted - d_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            part  <= '0;
            q_reg <= '0;
            d_mag <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            part  <= '0;
            q_reg <= mag(dividend);
            d_mag <= mag(divisor);
            neg_q <= dividend[W-1] ^ divisor[W-1];
            neg_r <= dividend[W-1];
        end else if (step) begin
            part  <= part_next;
            q_reg <= {q_reg[W-2:0], ~part_next[RW-1]};
        end
    end

    // The true remainder fits in W bits, so restoring in the low W bits is exact.
    always_comb begin
        rem_mag = part[RW-1] ? part[W-1:0] + d_mag : part[W-1:0];
        quot    = neg_q ? -q_reg : q_reg;
        rem     = neg_r ? -rem_mag : rem_mag;
    end

endmodule

// File: rtl/alu_seq.sv
// Fully registered sequential ALU: add/sub in one cycle, radix-2 Booth multiply,
// non-restoring divide. Status flags are built only when ALU_FLAGS_EN is defined.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [1:0]     op_select,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic [2*W-1:0] res,
    output logic           busy,
    output logic           done,
    output logic           err
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]     flags
`endif
);

    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    // Handshake: start is taken only while busy=0 (operands/op captured on that edge);
    // busy covers every following cycle through the single done pulse, and res/err
    // stay put until the next accepted start.
    state_t         state;
    state_t         state_next;
    logic [CNT_W-1:0] cnt;
    logic           accept;
    op_t            op_in;
    logic           div_zero;
    logic           div_ovf_q;

    logic [W:0]     add_sum;
    logic [W:0]     sub_diff;

    logic [W:0]     mul_a;
    logic [W:0]     mul_m;
    logic [W-1:0]   mul_q;
    logic           mul_q1;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_prod;

    logic [W-1:0]   div_quot;
    logic [W-1:0]   div_rem;

    logic           load_res;
    logic [2*W-1:0] res_next;
    logic           err_next;

    assign accept   = start && (state == S_IDLE);
    assign op_in    = op_t'(op_select);
    assign div_zero = (op_b == '0);
    assign add_sum  = {op_a[W-1], op_a} + {op_b[W-1], op_b};
    assign sub_diff = {op_a[W-1], op_a} - {op_b[W-1], op_b};

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_MUL:  state_next = S_MUL;
                        OP_DIV:  state_next = div_zero ? S_DONE : S_DIV;
                        default: state_next = S_DONE;
                    endcase
                end
            end
            S_MUL:     if (cnt == '0) state_next = S_DONE;
            S_DIV:     if (cnt == '0) state_next = S_DIV_FIX;
            S_DIV_FIX: state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            div_ovf_q <= 1'b0;
        end else if (accept) begin
            cnt       <= CNT_W'(W - 1);
            div_ovf_q <= (op_a == MIN_VAL) && (op_b == '1);
        end else if ((state == S_MUL || state == S_DIV) && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Booth step: W+1-bit accumulator so that subtracting the most negative multiplicand cannot overflow.
    always_comb begin
        case ({mul_q[0], mul_q1})
            2'b01:   mul_sum = mul_a + mul_m;
            2'b10:   mul_sum = mul_a - mul_m;
            default: mul_sum = mul_a;
        endcase
    end

    assign mul_prod = {mul_sum, mul_q[W-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a  <= '0;
            mul_m  <= '0;
            mul_q  <= '0;
            mul_q1 <= 1'b0;
        end else if (accept) begin
            mul_a  <= '0;
            mul_m  <= {op_b[W-1], op_b};
            mul_q  <= op_a;
            mul_q1 <= 1'b0;
        end else if (state == S_MUL) begin
            mul_a  <= {mul_sum[W], mul_sum[W:1]};
            mul_q  <= {mul_sum[0], mul_q[W-1:1]};
            mul_q1 <= mul_q[0];
        end
    end

    alu_div_core #(.W(W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (state == S_DIV),
        .dividend (op_a),
        .divisor  (op_b),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_comb begin
        load_res = 1'b0;
        res_next = res;
        err_next = err;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_ADD: begin
                            load_res = 1'b1;
                            res_next = {{(W-1){add_sum[W]}}, add_sum};
                            err_next = 1'b0;
                        end
                        OP_SUB: begin
                            load_res = 1'b1;
                            res_next = {{(W-1){sub_diff[W]}}, sub_diff};
                            err_next = 1'b0;
                        end
                        OP_DIV: begin
                            if (div_zero) begin
                                load_res = 1'b1;
                                res_next = {{W{1'b1}}, op_a};
                                err_next = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt == '0) begin
                    load_res = 1'b1;
                    res_next = mul_prod;
                    err_next = 1'b0;
                end
            end
            S_DIV_FIX: begin
                load_res = 1'b1;
                res_next = {div_quot, div_rem};
                err_next = div_ovf_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res <= '0;
            err <= 1'b0;
        end else if (load_res) begin
            res <= res_next;
            err <= err_next;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [W:0] mul_hi;
    logic       mul_fits;
    logic       v_next;
    logic       c_next;

    assign mul_hi   = mul_prod[2*W-1:W-1];
    assign mul_fits = (&mul_hi) | ~(|mul_hi);

    always_comb begin
        v_next = 1'b0;
        c_next = 1'b0;
        case (state)
            S_IDLE: begin
                case (op_in)
                    OP_ADD: begin
                        v_next = add_sum[W] ^ add_sum[W-1];
                        c_next = op_a > ~op_b;
                    end
                    OP_SUB: begin
                        v_next = sub_diff[W] ^ sub_diff[W-1];
                        c_next = op_a < op_b;
                    end
                    OP_DIV:  v_next = 1'b1;
                    default: ;
                endcase
            end
            S_MUL:     v_next = ~mul_fits;
            S_DIV_FIX: v_next = div_ovf_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else if (load_res) begin
            flags[FLAG_N] <= res_next[2*W-1];
            flags[FLAG_Z] <= (res_next == '0);
            flags[FLAG_V] <= v_next;
            flags[FLAG_C] <= c_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (W=16): directed vector table, randomized ops against an
// arithmetic reference model, and hand-built handshake / reset-abort sequences.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W       = 16;
    localparam int MAX_LAT = W + 10;
    localparam longint MIN_S = -(longint'(1) << (W - 1));
    localparam longint MAX_S = (longint'(1) << (W - 1)) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     op_select;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2*W-1:0] res;
    logic           busy;
    logic           done;
    logic           err;
`ifdef ALU_FLAGS_EN
    logic [3:0]     flags;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic           err;
        int             lat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_select (op_select),
        .op_a      (op_a),
        .op_b      (op_b),
        .res       (res),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef ALU_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [2*W-1:0] r, output logic e);
        longint sa, sb, v, q, rm;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = 1'b0;
        v  = 0;
        q  = 0;
        rm = 0;
        case (op)
            2'd0: begin v = sa + sb; r = v[2*W-1:0]; end
            2'd1: begin v = sa - sb; r = v[2*W-1:0]; end
            2'd2: begin v = sa * sb; r = v[2*W-1:0]; end
            default: begin
                if (sb == 0) begin
                    q = -1; rm = sa; e = 1'b1;
                end else if (sa == MIN_S && sb == -1) begin
                    q = MIN_S; rm = 0; e = 1'b1;
                end else begin
                    q = sa / sb; rm = sa % sb;
                end
                r = {q[W-1:0], rm[W-1:0]};
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] b);
        if (op == 2'd2) return W + 1;
        if (op == 2'd3) return (b == '0) ? 1 : W + 2;
        return 1;
    endfunction

`ifdef ALU_FLAGS_EN
    function automatic logic [3:0] model_flags(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] r;
        logic e, vf, c;
        longint sa, sb, v;
        model(op, a, b, r, e);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        vf = 1'b0;
        c  = 1'b0;
        case (op)
            2'd0: begin
                v = sa + sb; vf = (v > MAX_S) || (v < MIN_S);
                c = (longint'(a) + longint'(b)) >= (longint'(1) << W);
            end
            2'd1: begin v = sa - sb; vf = (v > MAX_S) || (v < MIN_S); c = (a < b); end
            2'd2: begin v = sa * sb; vf = (v > MAX_S) || (v < MIN_S); end
            default: vf = e;
        endcase
        return {r[2*W-1], (r == '0), vf, c};
    endfunction
`endif

    // ---------------- scoreboard / checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    // Entered and left at a falling edge with the DUT idle.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] r, output logic e, output int lat);
        op_select = op;
        op_a      = a;
        op_b      = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op_a      = W'($urandom);
        op_b      = W'($urandom);
        op_select = 2'($urandom);
        lat = -1;
        r   = '0;
        e   = 1'b0;
        for (int c = 1; c <= MAX_LAT; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                r   = res;
                e   = err;
                break;
            end
            start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        if (lat > 0) begin
            @(negedge clk);
            check("done_pulse_busy", {62'd0, done, busy}, 64'd0);
        end
    endtask

    task automatic run_and_check(input string name, input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [2*W-1:0] exp_res,
                                 input logic exp_err, input int exp_lat);
        logic [2*W-1:0] got_r;
        logic           got_e;
        int             got_lat;
        exp_q.push_back(exp_res);
        do_op(op, a, b, got_r, got_e, got_lat);
        check({name, " lat"}, 64'(got_lat), 64'(exp_lat));
        check({name, " res"}, 64'(got_r), 64'(exp_q.pop_front()));
        check({name, " err"}, 64'(got_e), 64'(exp_err));
`ifdef ALU_FLAGS_EN
        check({name, " flags"}, 64'(flags), 64'(model_flags(op, a, b)));
`endif
        if (got_lat < 0) do_reset();
    endtask

    // start held high across a multiply: re-accept right after done, operands changed while busy.
    task automatic test_handshake();
        int d1, d2, ndone;
        logic [2*W-1:0] r1, r2;
        d1 = -1; d2 = -1; ndone = 0; r1 = '0; r2 = '0;
        op_select = OP_MUL;
        op_a      = W'(-3);
        op_b      = W'(7);
        start     = 1'b1;
        @(posedge clk);
        #1;
        op_a = W'(5);
        op_b = W'(6);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1 = c; r1 = res; end
                else if (ndone == 2) begin d2 = c; r2 = res; start = 1'b0; end
            end
        end
        start = 1'b0;
        check("hs done count", 64'(ndone), 64'd2);
        check("hs first done cycle", 64'(d1), 64'd17);
        check("hs second done cycle", 64'(d2), 64'd35);
        check("hs first res", 64'(r1), 64'h0000_0000_FFFF_FFEB);
        check("hs second res", 64'(r2), 64'd30);
    endtask

    // Reset in cycle 5 of a divide, together with a start that must lose to reset.
    task automatic test_reset_abort();
        int ndone;
        run_and_check("pre_reset add", OP_ADD, W'(1), W'(1), 32'd2, 1'b0, 1);
        op_select = OP_DIV;
        op_a      = W'(-100);
        op_b      = W'(7);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset     = 1'b1;
        start     = 1'b1;
        op_select = OP_ADD;
        op_a      = W'(1);
        op_b      = W'(1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort res", 64'(res), 64'd0);
        check("abort err", 64'(err), 64'd0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort no done", 64'(ndone), 64'd0);
        run_and_check("post_reset add", OP_ADD, W'(2), W'(3), 32'd5, 1'b0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0]     rop;
        logic [W-1:0]   ra, rb;
        logic [2*W-1:0] rr;
        logic           re;

        vecs[0]  = '{2'd0, 16'h7FFF, 16'h0001, 32'h0000_8000, 1'b0, 1};
        vecs[1]  = '{2'd0, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFE, 1'b0, 1};
        vecs[2]  = '{2'd1, 16'h8000, 16'h0001, 32'hFFFF_7FFF, 1'b0, 1};
        vecs[3]  = '{2'd1, 16'h0000, 16'h8000, 32'h0000_8000, 1'b0, 1};
        vecs[4]  = '{2'd2, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB, 1'b0, 17};
        vecs[5]  = '{2'd2, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 17};
        vecs[6]  = '{2'd2, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 1'b0, 17};
        vecs[7]  = '{2'd3, 16'hFF9C, 16'h0007, 32'hFFF2_FFFE, 1'b0, 18};
        vecs[8]  = '{2'd3, 16'h04D2, 16'h0000, 32'hFFFF_04D2, 1'b1, 1};
        vecs[9]  = '{2'd3, 16'h8000, 16'hFFFF, 32'h8000_0000, 1'b1, 18};
        vecs[10] = '{2'd3, 16'h0007, 16'hFFFE, 32'hFFFD_0001, 1'b0, 18};
        vecs[11] = '{2'd3, 16'hFFF9, 16'h0002, 32'hFFFD_FFFF, 1'b0, 18};

        reset     = 1'b1;
        start     = 1'b0;
        op_select = 2'd0;
        op_a      = '0;
        op_b      = '0;
        do_reset();
        check("reset res", 64'(res), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
`ifdef ALU_FLAGS_EN
        check("reset flags", 64'(flags), 64'd0);
`endif

        for (int i = 0; i < NV; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].res, vecs[i].err, vecs[i].lat);
`ifdef ALU_FLAGS_EN
            if (i == 0) check("vec0 flags NZVC", 64'(flags), 64'b0010);
`endif
        end

        test_handshake();
        test_reset_abort();

        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            model(rop, ra, rb, rr, re);
            run_and_check($sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb,
                          rr, re, model_lat(rop, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
